// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline control path.
// Holds the sequencer state encoding and the bundled stage-control word.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 16;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_bubble;
  } ctrl_t;

  // Whole pipeline held, nothing written back
  localparam ctrl_t CTRL_FROZEN = ctrl_t'(7'b000_0001);
  localparam ctrl_t CTRL_FLOW   = ctrl_t'(7'b110_1010);
  localparam ctrl_t CTRL_BRANCH = ctrl_t'(7'b111_1110);
  localparam ctrl_t CTRL_BUBBLE = ctrl_t'(7'b000_1110);

  // Controls when memory is not holding the pipeline; a taken branch squashes
  // the ID instruction, so it outranks a load-use hazard on that instruction.
  function automatic ctrl_t run_ctrl(input logic branch_taken, input logic load_use);
    ctrl_t c;
    c = CTRL_FLOW;
    if (branch_taken) begin
      c = CTRL_BRANCH;
    end else if (load_use) begin
      c = CTRL_BUBBLE;
    end
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator between the ID sources and the EX load.
// Every register, R0 included, is treated as a real dependency.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  load_use
);

  logic hit_rs1;
  logic hit_rs2;

  assign hit_rs1  = id_uses_rs1 && (id_rs1 == ex_rd);
  assign hit_rs2  = id_uses_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_is_load && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the IF-ID-EX-MEM-WB pipeline with a memory timeout watchdog.
// Define HAZARD_PERF_CNT_EN to add the stall_cycles performance counter and perf_clr.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
`ifdef HAZARD_PERF_CNT_EN
  input  logic                  perf_clr,
  output logic [DATA_W-1:0]     stall_cycles,
`endif
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  idex_en,
  output logic                  idex_flush,
  output logic                  exmem_en,
  output logic                  memwb_bubble,
  output logic                  bus_err,
  output logic [1:0]            state_o
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_next;
  logic             bus_err_next;
  logic             load_use;
  logic             mem_stall;
  ctrl_t            ctrl;
  ctrl_t            ctrl_out;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  assign mem_stall = mem_req && !mem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      bus_err  <= bus_err_next;
    end
  end

  always_comb begin
    ctrl          = CTRL_FROZEN;
    state_next    = state;
    wait_cnt_next = wait_cnt;
    bus_err_next  = bus_err;
    unique case (state)
      ST_RUN: begin
        if (mem_stall) begin
          state_next    = ST_MEM_WAIT;
          wait_cnt_next = CNT_W'(1);
        end else begin
          ctrl = run_ctrl(branch_taken, load_use);
        end
      end
      ST_MEM_WAIT: begin
        // A pending branch survives the freeze in EX/MEM and is acted on here
        if (mem_ready) begin
          ctrl          = run_ctrl(branch_taken, load_use);
          state_next    = ST_RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_next   = ST_ERROR;
          bus_err_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end
      ST_ERROR: begin
        ctrl = CTRL_FROZEN;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Outputs are Mealy, so reset must mask them directly, not just via state
  assign ctrl_out     = reset ? ctrl : CTRL_FROZEN;
  assign pc_en        = ctrl_out.pc_en;
  assign ifid_en      = ctrl_out.ifid_en;
  assign ifid_flush   = ctrl_out.ifid_flush;
  assign idex_en      = ctrl_out.idex_en;
  assign idex_flush   = ctrl_out.idex_flush;
  assign exmem_en     = ctrl_out.exmem_en;
  assign memwb_bubble = ctrl_out.memwb_bubble;
  assign state_o      = reset ? state : ST_RUN;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (perf_clr) begin
      stall_cycles <= '0;
    end else if (!pc_en && (stall_cycles != {DATA_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule
